uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Receive half of the UART link: recovers 8N1 frames from serial RxD and holds
//   each received byte in a receive data register (RDR) for the host.
//   RxC is a 16x-baud sample-enable tick in the clk domain, not a clock; it comes
//   from the same baud generator that drives the transmitter.
//   Flags: RF (RDR full), OE (overrun), FE (framing error).
// PARAMETERS
//   OVERSAMPLE   16   RxC ticks per bit; the mid-bit sample falls at tick OVERSAMPLE/2-1 of the start bit
//   DATA_BITS    8    payload bits per frame, sent LSB first
//   SYNC_STAGES  2    flops in the RxD synchroniser (>=2)
// PORTS
//   clk     in   1          system clock; all logic on posedge
//   reset   in   1          synchronous, active-high reset
//   RxC     in   1          one-clk-wide sample tick at OVERSAMPLE x baud
//   RxD     in   1          asynchronous serial input; idle high
//   read    in   1          host consumed RDR; clears RF, OE and FE
//   dout    out  DATA_BITS  RDR contents; valid while RF=1
//   RF      out  1          RDR full flag
//   OE      out  1          overrun: a frame completed while RF=1
//   FE      out  1          framing error: stop bit sampled low
// BEHAVIOUR
//   Reset: state=IDLE, sync chain=all 1, tick cnt=0, bit cnt=0, RSR=0, dout=0, RF=0, OE=0, FE=0.
//   RxD passes through SYNC_STAGES flops; all FSM decisions use the synchronised value rxs.
//   The FSM and counters advance only on clk edges where RxC=1; RxC=0 holds them.
//   States:
//   - IDLE:  on a tick with rxs=0, go to START and set tick cnt=0.
//   - START: tick cnt++ each tick. At cnt=OVERSAMPLE/2-1 (7): if rxs=0, go to DATA with cnt=0, bit cnt=0;
//            if rxs=1, this is a false start (glitch); return to IDLE with no flag change.
//   - DATA:  cnt++ each tick. At cnt=OVERSAMPLE-1: RSR <= {rxs, RSR[DATA_BITS-1:1]}, cnt=0, bit cnt++.
//            After DATA_BITS bits, go to STOP.
//   - STOP:  at cnt=OVERSAMPLE-1 (middle of stop bit):
//            if rxs=0, FE<=1; the byte is still delivered.
//            Delivery: if RF=0, or read=1 in this same cycle, then dout<=RSR and RF<=1.
//            Otherwise OE<=1 and dout keeps the old byte (new byte dropped).
//            Return to IDLE in all cases.
//   Timing:
//   - RF rises 1 clk after the tick that samples the middle of the stop bit.
//   - Next start is detected as soon as rxs falls; no wait for the end of the stop bit.
//   read:
//   - read=1 clears RF, OE and FE on the next edge.
//   - If a delivery occurs in the same cycle, the delivery wins: RF=1, dout=new byte, FE=the new frame's value, OE=0.
//   - read while RF=0 has no effect besides clearing OE and FE.
//   Counter widths: tick cnt $clog2(OVERSAMPLE), bit cnt $clog2(DATA_BITS+1). No wrap beyond these terminal values.
//   reset=1 mid-frame aborts the frame at the next edge: all state returns to reset values; the partial byte is discarded.
// TESTING
//   1. Send 0xA5, 8N1, RxC every 4 clk -> RF=1, dout=8'hA5, OE=0, FE=0; RF rises 1 clk after the mid-stop tick.
//   2. Send 0x3C, read not asserted, then send 0x81 -> dout stays 8'h3C, OE=1;
//      pulse read -> RF=0, OE=0 next clk.
//   3. Send 0x55 with stop bit forced low -> dout=8'h55, RF=1, FE=1; read -> FE=0.
//   4. RxD low for 4 ticks, then high -> FSM back in IDLE, RF stays 0; next valid 0x0F is received as 8'h0F.
//   5. read pulsed in the exact cycle that 0x99 is delivered while RF=1 (old 0x12) -> dout=8'h99, RF=1, OE=0.
//   6. reset=1 during bit 4 of a frame, released, then send 0xF0 -> all outputs 0 after reset; dout=8'hF0, no FE/OE.

Source files
------------

// File: rtl/uart_receiver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_receiver_if
// Purpose  : Groups the UART receiver's sample tick, serial line, host read
//            strobe and receive-data-register outputs into one bundle.
// Signals  : RxC  - one-clk sample tick at OVERSAMPLE x baud (host -> rx)
//            RxD  - asynchronous serial line, idle high   (host -> rx)
//            read - host consumed the RDR                 (host -> rx)
//            dout - RDR contents, valid while RF=1        (rx -> host)
//            RF   - RDR full                              (rx -> host)
//            OE   - overrun: frame completed while RF=1   (rx -> host)
//            FE   - framing error: stop bit sampled low   (rx -> host)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 RxC;
  logic                 RxD;
  logic                 read;
  logic [DATA_BITS-1:0] dout;
  logic                 RF;
  logic                 OE;
  logic                 FE;

  // Host / bench side
  modport master (output RxC, RxD, read, input dout, RF, OE, FE);
  // Receiver side
  modport slave  (input RxC, RxD, read, output dout, RF, OE, FE);
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : Receive half of a UART link. Recovers 8N1-style frames from the
//            serial line using an oversampling tick and holds each byte in a
//            receive data register with full / overrun / framing flags.
// Ports    : clk   - system clock, all logic on posedge
//            reset - synchronous, active-high reset
//            bus   - uart_receiver_if.slave (RxC, RxD, read in;
//                    dout, RF, OE, FE out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LAST    = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          tick_q,  tick_d;
  logic [BW-1:0]          bit_q,   bit_d;
  logic [DATA_BITS-1:0]   rsr_q,   rsr_d;
  logic [DATA_BITS-1:0]   dout_q,  dout_d;
  logic                   rf_q,    rf_d;
  logic                   oe_q,    oe_d;
  logic                   fe_q,    fe_d;
  logic                   rxs;

  // Synchronised serial input; the chain resets to the idle (high) level
  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      tick_q  <= '0;
      bit_q   <= '0;
      rsr_q   <= '0;
      dout_q  <= '0;
      rf_q    <= 1'b0;
      oe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.RxD};
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      rsr_q   <= rsr_d;
      dout_q  <= dout_d;
      rf_q    <= rf_d;
      oe_q    <= oe_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    rsr_d   = rsr_q;
    dout_d  = dout_q;
    rf_d    = rf_q;
    oe_d    = oe_q;
    fe_d    = fe_q;

    // Host read clears the flags; a delivery below overrides this
    if (bus.read) begin
      rf_d = 1'b0;
      oe_d = 1'b0;
      fe_d = 1'b0;
    end

    if (bus.RxC) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == C_HALF_M1) begin
            if (!rxs) begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              // Line went back high before mid-start: glitch, not a frame
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == C_FULL_M1) begin
            rsr_d  = {rxs, rsr_q[DATA_BITS-1:1]};
            tick_d = '0;
            bit_d  = bit_q + BW'(1);
            if (bit_q == C_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        S_STOP: begin
          if (tick_q == C_FULL_M1) begin
            state_d = S_IDLE;
            tick_d  = '0;
            // A read in this same cycle frees the RDR for the new byte
            if (!rf_q || bus.read) begin
              dout_d = rsr_q;
              rf_d   = 1'b1;
              oe_d   = 1'b0;
              fe_d   = !rxs;
            end else begin
              oe_d = 1'b1;
              fe_d = fe_q | !rxs;
            end
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.RF   = rf_q;
  assign bus.OE   = oe_q;
  assign bus.FE   = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver. Serial frames are built
//            from bytes and compared against a byte-level model of the
//            receive data register and its RF/OE/FE flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int SS       = 2;
  localparam int TICK     = 4;
  localparam int BIT_CLKS = OS * TICK;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  uart_receiver_if #(.DATA_BITS(DB)) bus ();

  uart_receiver #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Number of posedges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // Sample tick: edges whose number is a multiple of TICK see RxC=1
  initial begin
    bus.RxC = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.RxC = ((cyc + 1) % TICK == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (byte level) ----------------
  logic [DB-1:0] m_dout;
  logic          m_rf, m_oe, m_fe;

  function automatic void model_reset();
    m_dout = '0; m_rf = 1'b0; m_oe = 1'b0; m_fe = 1'b0;
  endfunction

  function automatic void model_read();
    m_rf = 1'b0; m_oe = 1'b0; m_fe = 1'b0;
  endfunction

  // A completed frame either lands in the RDR or is dropped as an overrun
  function automatic void model_frame(input logic [DB-1:0] b, input bit stop_hi, input bit rd);
    if (!m_rf || rd) begin
      m_dout = b; m_rf = 1'b1; m_oe = 1'b0; m_fe = !stop_hi;
    end else begin
      m_oe = 1'b1; m_fe = m_fe | !stop_hi;
    end
  endfunction

  function automatic logic [DB+2:0] st();
    return {bus.dout, bus.RF, bus.OE, bus.FE};
  endfunction

  function automatic logic [DB+2:0] mst();
    return {m_dout, m_rf, m_oe, m_fe};
  endfunction

  // Edge on which the mid-stop tick falls for a frame whose start bit is
  // driven right after edge c0: the line reaches the FSM SS+1 edges later,
  // start is seen on the next tick, then OS/2 + DB*OS + OS ticks follow.
  function automatic int mid_stop_edge(input int c0);
    int e;
    e = c0 + SS + 1;
    while (e % TICK != 0) e++;
    return e + (OS / 2 + OS * DB + OS) * TICK;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e) step(1);
  endtask

  task automatic send_bit(input logic b);
    bus.RxD = b;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input bit stop_hi);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(b[i]);
    send_bit(stop_hi);
  endtask

  task automatic pulse_read();
    bus.read = 1'b1;
    step(1);
    bus.read = 1'b0;
    model_read();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; bus.RxD = 1'b1; bus.read = 1'b0;
    step(3);
    model_reset();
    tests++;
    if (st() !== {{DB{1'b0}}, 3'b000}) begin
      fails++; $display("FAIL reset_state: got %h expected %h", st(), {{DB{1'b0}}, 3'b000});
    end
    reset = 1'b0;
    step(2);
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL reset_release: got %h expected %h", st(), mst());
    end
  endtask

  task automatic test_single_frame();
    int c0, s;
    c0 = cyc;
    s  = mid_stop_edge(c0);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        goto_edge(s - 1);
        tests++;
        if (bus.RF !== 1'b0) begin
          fails++; $display("FAIL t1_rf_before_tick: got %b expected 0", bus.RF);
        end
        goto_edge(s);
        tests++;
        if (bus.RF !== 1'b1) begin
          fails++; $display("FAIL t1_rf_after_tick: got %b expected 1", bus.RF);
        end
      end
    join
    model_frame(8'hA5, 1'b1, 1'b0);
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t1_frame: got %h expected %h", st(), mst());
    end
    tests++;
    if (bus.dout !== 8'hA5) begin
      fails++; $display("FAIL t1_dout: got %h expected a5", bus.dout);
    end
    pulse_read();
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t1_read: got %h expected %h", st(), mst());
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1, 1'b0);
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t2_overrun: got %h expected %h", st(), mst());
    end
    tests++;
    if (bus.dout !== 8'h3C || bus.OE !== 1'b1) begin
      fails++; $display("FAIL t2_dout_oe: got dout=%h OE=%b expected dout=3c OE=1", bus.dout, bus.OE);
    end
    pulse_read();
    tests++;
    if (bus.RF !== 1'b0 || bus.OE !== 1'b0) begin
      fails++; $display("FAIL t2_read_clear: got RF=%b OE=%b expected RF=0 OE=0", bus.RF, bus.OE);
    end
  endtask

  task automatic test_framing_error();
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0, 1'b0);
    send_bit(1'b1);
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t3_framing: got %h expected %h", st(), mst());
    end
    tests++;
    if (bus.dout !== 8'h55 || bus.FE !== 1'b1 || bus.RF !== 1'b1) begin
      fails++; $display("FAIL t3_fe_set: got dout=%h RF=%b FE=%b expected 55 1 1", bus.dout, bus.RF, bus.FE);
    end
    pulse_read();
    tests++;
    if (bus.FE !== 1'b0) begin
      fails++; $display("FAIL t3_fe_clear: got %b expected 0", bus.FE);
    end
  endtask

  task automatic test_false_start();
    bus.RxD = 1'b0;
    step(4 * TICK);
    bus.RxD = 1'b1;
    step(BIT_CLKS);
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t4_glitch: got %h expected %h", st(), mst());
    end
    send_frame(8'h0F, 1'b1);
    model_frame(8'h0F, 1'b1, 1'b0);
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t4_after_glitch: got %h expected %h", st(), mst());
    end
    tests++;
    if (bus.dout !== 8'h0F) begin
      fails++; $display("FAIL t4_dout: got %h expected 0f", bus.dout);
    end
    pulse_read();
  endtask

  task automatic test_read_collision();
    int c0, s;
    send_frame(8'h12, 1'b1);
    model_frame(8'h12, 1'b1, 1'b0);
    c0 = cyc;
    s  = mid_stop_edge(c0);
    fork
      send_frame(8'h99, 1'b1);
      begin
        goto_edge(s - 1);
        bus.read = 1'b1;
        goto_edge(s);
        bus.read = 1'b0;
        model_frame(8'h99, 1'b1, 1'b1);
        tests++;
        if (st() !== mst()) begin
          fails++; $display("FAIL t5_collision: got %h expected %h", st(), mst());
        end
      end
    join
    tests++;
    if (bus.dout !== 8'h99 || bus.RF !== 1'b1 || bus.OE !== 1'b0) begin
      fails++; $display("FAIL t5_delivery_wins: got dout=%h RF=%b OE=%b expected 99 1 0", bus.dout, bus.RF, bus.OE);
    end
    pulse_read();
  endtask

  task automatic test_reset_midframe();
    logic [DB-1:0] b;
    b = DB'($urandom);
    send_frame(b, 1'b1);
    model_frame(b, 1'b1, 1'b0);
    b = DB'($urandom);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    bus.RxD = b[4];
    step(BIT_CLKS / 2);
    reset = 1'b1;
    step(1);
    model_reset();
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t6_reset_outputs: got %h expected %h", st(), mst());
    end
    bus.RxD = 1'b1;
    reset   = 1'b0;
    step(2 * BIT_CLKS);
    tests++;
    if (st() !== mst()) begin
      fails++; $display("FAIL t6_partial_discarded: got %h expected %h", st(), mst());
    end
    send_frame(8'hF0, 1'b1);
    model_frame(8'hF0, 1'b1, 1'b0);
    tests++;
    if (st() !== mst() || bus.dout !== 8'hF0) begin
      fails++; $display("FAIL t6_after_reset: got %h expected %h", st(), mst());
    end
    pulse_read();
  endtask

  task automatic test_back_to_back_random();
    logic [DB-1:0] b;
    bit            stop_hi;
    for (int n = 0; n < 12; n++) begin
      b       = DB'($urandom);
      stop_hi = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_hi);
      model_frame(b, stop_hi, 1'b0);
      if (!stop_hi) send_bit(1'b1);
      tests++;
      if (st() !== mst()) begin
        fails++; $display("FAIL rand_frame_%0d: got %h expected %h", n, st(), mst());
      end
      if ($urandom_range(0, 1) == 1) pulse_read();
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.RxD  = 1'b1;
    bus.read = 1'b0;
    model_reset();
    step(1);
    test_reset();
    test_single_frame();
    test_overrun();
    test_framing_error();
    test_false_start();
    test_read_collision();
    test_reset_midframe();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
